// File: rtl/chest_freq_interp.sv
`default_nettype none
// ============================================================================
//  Module   : chest_freq_interp
//  Purpose  : Frequency-domain linear interpolator for one NB-IoT PRB. Takes
//             the four averaged pilot estimates E1..E4 and streams twelve
//             per-subcarrier channel estimates, one per cycle. Handles one
//             component (real or imaginary); instantiate once per component.
//             Pilots sit at subcarriers shift + 3k, k = 0..3. Subcarriers
//             between pilots are linearly interpolated, and those outside the
//             pilot span hold the nearest pilot.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-low reset
//             start      - capture E1..E4/shift, accepted only while busy = 0
//             shift[1:0] - pilot offset 0..2 (3 behaves as 0)
//             E1..E4     - signed pilot estimates at p_0..p_3
//             h_out      - interpolated estimate for subcarrier sc_idx
//             sc_idx     - subcarrier index 0..11
//             out_valid  - h_out/sc_idx valid this cycle
//             busy       - a PRB is in progress
//             done       - one-cycle pulse alongside the sc_idx = 11 output
//  Macro    : INTERP_ROUND_EN - when defined, round-half-up the interpolated
//             values; otherwise floor via arithmetic shift.
//  Revision : 1.0 - initial release
// ============================================================================
module chest_freq_interp #(
    parameter int WIDTH_EST = 17
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  shift,
    input  logic signed [WIDTH_EST-1:0] E1,
    input  logic signed [WIDTH_EST-1:0] E2,
    input  logic signed [WIDTH_EST-1:0] E3,
    input  logic signed [WIDTH_EST-1:0] E4,
    output logic signed [WIDTH_EST-1:0] h_out,
    output logic [3:0]                  sc_idx,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int SW = WIDTH_EST + 2;   // width of the weighted sum S
    localparam int PW = WIDTH_EST + 18;  // width of the product P

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // 21846 / 65536 ~= 1/3, so (S * 21846) >>> 16 ~= S / 3
    localparam logic signed [PW-1:0] COEF    = PW'(21846);
`ifdef INTERP_ROUND_EN
    localparam logic signed [PW-1:0] ROUND   = PW'(32768);
`endif
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-WIDTH_EST+1){1'b0}}, {(WIDTH_EST-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]                  state;
    logic [1:0]                  state_next;
    logic [3:0]                  n;
    logic [1:0]                  s_q;
    logic signed [WIDTH_EST-1:0] e_q [0:3];
    logic                        accept;

    // datapath intermediates
    logic                        lo_hold;
    logic                        hi_hold;
    logic [3:0]                  m;
    logic [1:0]                  k;
    logic [1:0]                  d;
    logic signed [WIDTH_EST-1:0] ea;
    logic signed [WIDTH_EST-1:0] eb;
    logic signed [SW-1:0]        ea_x;
    logic signed [SW-1:0]        eb_x;
    logic signed [SW-1:0]        s_sum;
    logic signed [PW-1:0]        s_ext;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_adj;
    logic signed [PW-1:0]        shifted;
    logic signed [WIDTH_EST-1:0] interp;
    logic signed [WIDTH_EST-1:0] h_next;

    // registered-output next values
    logic                        valid_next;
    logic                        done_next;
    logic                        busy_next;

    assign accept = (state == S_IDLE) && start;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (n == 4'd11) state_next = S_DRAIN;
            S_DRAIN: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values for the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        valid_next = (state == S_RUN);
        done_next  = (state == S_RUN) && (n == 4'd11);
        // busy follows the state we are about to enter, so it rises the
        // cycle after start and falls the cycle after DRAIN.
        busy_next  = (state_next != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Capture registers and subcarrier counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n      <= 4'd0;
            s_q    <= 2'd0;
            e_q[0] <= '0;
            e_q[1] <= '0;
            e_q[2] <= '0;
            e_q[3] <= '0;
        end else if (accept) begin
            n      <= 4'd0;
            s_q    <= (shift == 2'd3) ? 2'd0 : shift;
            e_q[0] <= E1;
            e_q[1] <= E2;
            e_q[2] <= E3;
            e_q[3] <= E4;
        end else if ((state == S_RUN) && (n != 4'd11)) begin
            n <= n + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Interpolation datapath for subcarrier n
    // ------------------------------------------------------------------
    always_comb begin
        lo_hold = (n < {2'b00, s_q});
        hi_hold = (n > ({2'b00, s_q} + 4'd9));
        // offset from the first pilot; only meaningful when neither hold applies
        m = n - {2'b00, s_q};
        case (m)
            4'd0:    begin k = 2'd0; d = 2'd0; end
            4'd1:    begin k = 2'd0; d = 2'd1; end
            4'd2:    begin k = 2'd0; d = 2'd2; end
            4'd3:    begin k = 2'd1; d = 2'd0; end
            4'd4:    begin k = 2'd1; d = 2'd1; end
            4'd5:    begin k = 2'd1; d = 2'd2; end
            4'd6:    begin k = 2'd2; d = 2'd0; end
            4'd7:    begin k = 2'd2; d = 2'd1; end
            4'd8:    begin k = 2'd2; d = 2'd2; end
            default: begin k = 2'd3; d = 2'd0; end
        endcase

        ea   = e_q[k];
        // wraps to e_q[0] for k = 3, where d is always 0 and eb is unused
        eb   = e_q[k + 2'd1];
        ea_x = {{2{ea[WIDTH_EST-1]}}, ea};
        eb_x = {{2{eb[WIDTH_EST-1]}}, eb};

        // (3-d)*Ea + d*Eb for d = 1 or 2
        s_sum = (d == 2'd1) ? (ea_x + ea_x + eb_x) : (ea_x + eb_x + eb_x);
        s_ext = {{(PW-SW){s_sum[SW-1]}}, s_sum};
        prod  = s_ext * COEF;
`ifdef INTERP_ROUND_EN
        prod_adj = prod + ROUND;
`else
        prod_adj = prod;
`endif
        shifted = prod_adj >>> 16;

        if (shifted > SAT_MAX) begin
            interp = SAT_MAX[WIDTH_EST-1:0];
        end else if (shifted < SAT_MIN) begin
            interp = SAT_MIN[WIDTH_EST-1:0];
        end else begin
            interp = shifted[WIDTH_EST-1:0];
        end

        // pilot positions and held edges bypass the multiplier entirely
        if (lo_hold) begin
            h_next = e_q[0];
        end else if (hi_hold) begin
            h_next = e_q[3];
        end else if (d == 2'd0) begin
            h_next = ea;
        end else begin
            h_next = interp;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_out     <= '0;
            sc_idx    <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_valid <= valid_next;
            done      <= done_next;
            busy      <= busy_next;
            // h_out and sc_idx hold their last values between PRBs
            if (valid_next) begin
                h_out  <= h_next;
                sc_idx <= n;
            end
        end
    end

endmodule
`default_nettype wire
